// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, alu_op and FSM state encodings for the ctrl_seq sequencer.
package ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_EXEC, S_WRITE, S_HLT} state_t;
   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_STORE = 3'b010;
   localparam logic [2:0] OP_ADD   = 3'b011;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_HALT  = 3'b111;
   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_AND  = 2'b11;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   i_op      : opcode field of the incoming instruction
//   o_next    : state the sequencer enters on accept (IDLE for NOP/illegal)
//   o_alu     : alu_op to apply in EXEC
//   o_illegal : opcode is undefined (110 or any upper opcode bit set)
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int INSTR_BITS = 3
) (
   input  logic [INSTR_BITS-1:0] i_op,
   output state_t                o_next,
   output logic [1:0]            o_alu,
   output logic                  o_illegal
);
   logic w_hi_set;
   assign w_hi_set = |(i_op >> 3);
   always_comb begin
      o_next    = S_IDLE;
      o_alu     = ALU_PASS;
      o_illegal = w_hi_set;
      if (!w_hi_set) begin
         case (i_op[2:0])
            OP_NOP:   o_next = S_IDLE;
            OP_LOAD:  o_next = S_READ;
            OP_STORE: o_next = S_WRITE;
            OP_ADD:   begin o_next = S_READ; o_alu = ALU_ADD; end
            OP_SUB:   begin o_next = S_READ; o_alu = ALU_SUB; end
            OP_AND:   begin o_next = S_READ; o_alu = ALU_AND; end
            OP_HALT:  o_next = S_HLT;
            default:  o_illegal = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer driving memory/accumulator control lines.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : instruction handshake, value = {opcode, address}
//   resume              : leave HALT
//   mem_addr/mem_rd/mem_wr : memory address and strobes
//   alu_op/acc_we       : accumulator control, alu_op only non-PASS in EXEC
//   halted/illegal      : HALT state flag, one-cycle undefined-opcode pulse
//   retired             : wrapping completed-instruction count
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter  int ADDRESS_BITS = 5,
   parameter  int INSTR_BITS   = 3,
   parameter  int READ_LATENCY = 1,
   parameter  int COUNT_BITS   = 16,
   localparam int VALUE_BITS   = INSTR_BITS + ADDRESS_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [VALUE_BITS-1:0]   value,
   input  logic                    resume,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic                    mem_rd,
   output logic                    mem_wr,
   output logic [1:0]              alu_op,
   output logic                    acc_we,
   output logic                    halted,
   output logic                    illegal,
   output logic [COUNT_BITS-1:0]   retired
);
   localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
   state_t                  r_state, w_next, w_dec_next;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic [1:0]              r_alu, w_dec_alu;
   logic                    r_illegal, w_dec_ill, w_accept, w_retire;
   logic [2:0]              r_cnt;
   logic [COUNT_BITS-1:0]   r_retired;
   ctrl_decode #(.INSTR_BITS(INSTR_BITS)) u_dec (
      .i_op      (value[VALUE_BITS-1:ADDRESS_BITS]),
      .o_next    (w_dec_next),
      .o_alu     (w_dec_alu),
      .o_illegal (w_dec_ill)
   );
   assign w_accept = in_valid && (r_state == S_IDLE);
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) begin
            w_next   = w_dec_next;
            // NOP and HALT retire on accept; illegal is never counted
            w_retire = !w_dec_ill && (w_dec_next == S_IDLE || w_dec_next == S_HLT);
         end
         S_READ:  w_next = (READ_LATENCY == 1) ? S_EXEC : S_WAIT;
         S_WAIT:  w_next = (r_cnt == 3'd0) ? S_EXEC : S_WAIT;
         S_EXEC:  begin w_next = S_IDLE; w_retire = 1'b1; end
         S_WRITE: begin w_next = S_IDLE; w_retire = 1'b1; end
         S_HLT:   w_next = resume ? S_IDLE : S_HLT;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_alu     <= ALU_PASS;
         r_illegal <= 1'b0;
         r_cnt     <= 3'd0;
         r_retired <= '0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_accept && w_dec_ill;
         r_retired <= r_retired + COUNT_BITS'(w_retire);
         if (w_accept) begin
            r_addr <= value[ADDRESS_BITS-1:0];
            r_alu  <= w_dec_alu;
         end
         if (r_state == S_READ) r_cnt <= WAIT_INIT;
         else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      end
   end
   assign in_ready = (r_state == S_IDLE);
   assign mem_addr = r_addr;
   assign mem_rd   = (r_state == S_READ);
   assign mem_wr   = (r_state == S_WRITE);
   assign acc_we   = (r_state == S_EXEC);
   assign alu_op   = (r_state == S_EXEC) ? r_alu : ALU_PASS;
   assign halted   = (r_state == S_HLT);
   assign illegal  = r_illegal;
   assign retired  = r_retired;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: vector-table and directed-sequence bench for ctrl_seq.
module tb_ctrl_seq;
   logic clk, rst_n, in_valid, resume;
   logic [7:0] value;
   logic rdy0, rd0, wr0, we0, h0, ill0;
   logic [4:0] addr0;
   logic [1:0] alu0;
   logic [15:0] ret0;
   logic rdy1, rd1, wr1, we1, h1, ill1;
   logic [4:0] addr1;
   logic [1:0] alu1;
   logic [15:0] ret1;
   logic rdy2, rd2, wr2, we2, h2, ill2;
   logic [4:0] addr2;
   logic [1:0] alu2;
   logic [3:0] ret2;
   int n_vec = 0, n_err = 0;

   ctrl_seq #(.READ_LATENCY(1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .value(value), .resume(resume),
      .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0), .alu_op(alu0), .acc_we(we0),
      .halted(h0), .illegal(ill0), .retired(ret0));
   ctrl_seq #(.READ_LATENCY(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .value(value), .resume(resume),
      .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .alu_op(alu1), .acc_we(we1),
      .halted(h1), .illegal(ill1), .retired(ret1));
   ctrl_seq #(.READ_LATENCY(1), .COUNT_BITS(4)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .value(value), .resume(resume),
      .mem_addr(addr2), .mem_rd(rd2), .mem_wr(wr2), .alu_op(alu2), .acc_we(we2),
      .halted(h2), .illegal(ill2), .retired(ret2));

   typedef struct packed {
      logic vld; logic [7:0] val; logic res;
      logic rdy; logic [4:0] addr; logic rd; logic wr; logic [1:0] alu;
      logic we; logic hlt; logic ill; logic [15:0] ret;
   } vec_t;
   vec_t tbl [24];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; value = 8'h00; resume = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int we_seen;
      //          vld   val    res   rdy   addr   rd    wr    alu   we    hlt   ill   ret
      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 8'h25, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[4]  = '{1'b1, 8'h4A, 1'b0, 1'b0, 5'd10, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd2};
      tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3};
      tbl[7]  = '{1'b1, 8'hC3, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd3};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3};
      tbl[9]  = '{1'b1, 8'h67, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 16'd3};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4};
      tbl[12] = '{1'b1, 8'hA1, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'd4};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd5};
      tbl[15] = '{1'b1, 8'h82, 1'b0, 1'b0, 5'd2,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd5};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 16'd5};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd6};
      tbl[18] = '{1'b1, 8'hE4, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd7};
      tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd7};
      tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd7};
      tbl[21] = '{1'b1, 8'h00, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd7};
      tbl[22] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd8};
      tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd8};

      rst_n = 1'b0; in_valid = 1'b0; value = 8'h00; resume = 1'b0;
      step(); step();
      chk("reset_state", {3'b0, rdy0, addr0, rd0, wr0, alu0, we0, h0, ill0, ret0}, {3'b0, 1'b1, 28'd0});
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         in_valid = tbl[i].vld; value = tbl[i].val; resume = tbl[i].res;
         step();
         chk($sformatf("vec%0d", i), {3'b0, rdy0, addr0, rd0, wr0, alu0, we0, h0, ill0, ret0},
             {3'b0, tbl[i].rdy, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].alu, tbl[i].we,
              tbl[i].hlt, tbl[i].ill, tbl[i].ret});
      end

      // READ_LATENCY=4, SUB 0x1F
      do_reset();
      in_valid = 1'b1; value = 8'h9F;
      step();
      in_valid = 1'b0;
      chk("lat4_rd", {24'b0, rdy1, rd1, we1, 5'b0}, {24'b0, 1'b0, 1'b1, 1'b0, 5'b0});
      chk("lat4_addr", {27'b0, addr1}, 32'd31);
      for (int j = 2; j <= 4; j++) begin
         step();
         chk($sformatf("lat4_wait%0d", j), {29'b0, rdy1, rd1, we1}, 32'd0);
      end
      step();
      chk("lat4_exec", {27'b0, rdy1, we1, alu1, 1'b0}, {27'b0, 1'b0, 1'b1, 2'b10, 1'b0});
      step();
      chk("lat4_ready", {15'b0, rdy1, ret1}, {15'b0, 1'b1, 16'd1});

      // async reset during WAIT of ADD aborts it
      do_reset();
      in_valid = 1'b1; value = 8'h67;
      step();
      in_valid = 1'b0;
      step();
      chk("abort_in_wait", {29'b0, rdy1, rd1, we1}, 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_reset_vals", {3'b0, rdy1, addr1, rd1, wr1, alu1, we1, h1, ill1, ret1}, {3'b0, 1'b1, 28'd0});
      step();
      rst_n = 1'b1;
      we_seen = 0;
      for (int j = 0; j < 6; j++) begin
         step();
         if (we1) we_seen++;
      end
      chk("abort_no_acc_we", 32'(we_seen), 32'd0);
      chk("abort_retired", {15'b0, rdy1, ret1}, {15'b0, 1'b1, 16'd0});

      // 4-bit counter wraps after 16 NOPs
      do_reset();
      in_valid = 1'b1; value = 8'h00;
      for (int n = 1; n <= 17; n++) begin
         step();
         if (n >= 15) chk($sformatf("wrap_nop%0d", n), {28'b0, ret2}, {28'b0, 4'(n)});
      end
      in_valid = 1'b0;
      step();
      chk("wrap_final", {27'b0, rdy2, ret2}, {27'b0, 1'b1, 4'd1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
